// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V widths, opcodes and fetch FSM encoding
package riscv_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Major opcodes, also consumed by the decode controller.
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory, redirect and decode-side handshake bundle
interface instr_fetch_if import riscv_pkg::*; #(
    parameter int AW = riscv_pkg::XLEN
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;
    logic [6:0]    opcode;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc, opcode,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc, opcode,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch unit with PC redirect
module instr_fetch import riscv_pkg::*; #(
    parameter int               XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic           clk,
    input  logic           reset_n,
    instr_fetch_if.master  bus
);
    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr_pc_q;
    logic [31:0]     instr_q;
    logic            drop;

    assign bus.imem_req    = (state == FETCH);
    assign bus.imem_addr   = {pc[XLEN-1:2], 2'b00};
    assign bus.instr_valid = (state == HOLD);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.opcode      = instr_q[6:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.redirect_valid)
                        pc <= bus.redirect_pc;
                    // A redirect on the grant cycle makes the granted response stale.
                    if (bus.imem_gnt) begin
                        drop  <= bus.redirect_valid;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (drop || bus.redirect_valid) begin
                            drop  <= 1'b0;
                            if (bus.redirect_valid)
                                pc <= bus.redirect_pc;
                            state <= FETCH;
                        end else begin
                            instr_q    <= bus.imem_rdata;
                            instr_pc_q <= {pc[XLEN-1:2], 2'b00};
                            pc         <= pc + XLEN'(4);
                            state      <= HOLD;
                        end
                    end else if (bus.redirect_valid) begin
                        pc   <= bus.redirect_pc;
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid) begin
                        pc    <= bus.redirect_pc;
                        state <= FETCH;
                    end else if (bus.instr_ready) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;
    import riscv_pkg::*;

    logic clk;
    logic reset_n;
    logic rst2_n;

    instr_fetch_if bus();
    instr_fetch_if bus2();

    instr_fetch u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
        .clk     (clk),
        .reset_n (rst2_n),
        .bus     (bus2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_req_q[$];
    logic [31:0] exp_ins_q[$];
    logic [31:0] exp_pc_q[$];

    bit gnt_en;
    int lat;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_ins(input logic [31:0] ins, input logic [31:0] pc);
        exp_ins_q.push_back(ins);
        exp_pc_q.push_back(pc);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h00A0_0093;
            32'h0000_0004: return 32'h0020_8133;
            32'h0000_0008: return 32'h0000_A183;
            32'h0000_0040: return 32'hFE00_0EE3;
            32'h0000_0080: return 32'h0031_0233;
            32'h0000_0100: return 32'h0011_2023;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Memory model for the first DUT: grants when gnt_en, answers lat cycles late.
    initial begin
        bit          pend;
        int          cnt;
        logic [31:0] paddr;
        pend = 0;
        cnt  = 0;
        paddr = '0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            bus.imem_rvalid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(paddr);
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
            bus.imem_gnt = gnt_en;
            if (bus.imem_req && gnt_en && reset_n) begin
                pend  = 1;
                paddr = bus.imem_addr;
                cnt   = lat;
            end
        end
    end

    // Request monitor
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && bus.imem_req && bus.imem_gnt) begin
                if (exp_req_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL req_unexpected: got addr %h expected no request", bus.imem_addr);
                end else begin
                    e = exp_req_q.pop_front();
                    chk("req_addr", bus.imem_addr, e);
                end
            end
        end
    end

    // Instruction handshake monitor
    initial begin
        logic [31:0] ei;
        logic [31:0] ep;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && bus.instr_valid && bus.instr_ready) begin
                if (exp_ins_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL instr_unexpected: got instr %h pc %h expected none", bus.instr, bus.instr_pc);
                end else begin
                    ei = exp_ins_q.pop_front();
                    ep = exp_pc_q.pop_front();
                    chk("instr", bus.instr, ei);
                    chk("instr_pc", bus.instr_pc, ep);
                    chk("opcode", {25'b0, bus.opcode}, {25'b0, ei[6:0]});
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        rst2_n  = 1'b0;
        gnt_en  = 1'b0;
        lat     = 0;
        bus.instr_ready     = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus2.imem_gnt       = 1'b0;
        bus2.imem_rvalid    = 1'b0;
        bus2.imem_rdata     = '0;
        bus2.instr_ready    = 1'b0;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;

        repeat (3) @(negedge clk);
        #3;
        chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("rst_instr", bus.instr, 32'h0000_0013);
        chk("rst_instr_pc", bus.instr_pc, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'd0);
        chk("rst_req", {31'b0, bus.imem_req}, 32'd1);
        chk("rst_opcode", {25'b0, bus.opcode}, {25'b0, OP_IMM});
        chk("rst2_addr", bus2.imem_addr, 32'hFFFF_FFFC);

        // Streaming fetch, then back-pressure on the second instruction.
        @(negedge clk);
        reset_n = 1'b1;
        gnt_en  = 1'b1;
        bus.instr_ready = 1'b1;
        exp_req_q.push_back(32'h0);
        exp_req_q.push_back(32'h4);
        exp_req_q.push_back(32'h8);
        push_ins(32'h00A0_0093, 32'h0);
        push_ins(32'h0020_8133, 32'h4);
        push_ins(32'h0000_A183, 32'h8);
        repeat (3) @(negedge clk);
        bus.instr_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #3;
            chk("bp_valid", {31'b0, bus.instr_valid}, 32'd1);
            chk("bp_instr", bus.instr, 32'h0020_8133);
            chk("bp_instr_pc", bus.instr_pc, 32'h4);
            chk("bp_req", {31'b0, bus.imem_req}, 32'd0);
        end
        @(negedge clk);
        bus.instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        gnt_en = 1'b0;

        // Redirect while waiting for a slow response.
        @(negedge clk);
        gnt_en = 1'b1;
        lat    = 2;
        exp_req_q.push_back(32'hC);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        lat = 0;
        exp_req_q.push_back(32'h100);
        push_ins(32'h0011_2023, 32'h100);
        repeat (5) @(negedge clk);

        // Redirect coincident with grant.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0040;
        exp_req_q.push_back(32'h104);
        exp_req_q.push_back(32'h40);
        push_ins(32'hFE00_0EE3, 32'h40);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Redirect coincident with a completing handshake.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0080;
        exp_req_q.push_back(32'h80);
        push_ins(32'h0031_0233, 32'h80);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #3;
        chk("no_dup_valid", {31'b0, bus.instr_valid}, 32'd0);
        repeat (3) @(negedge clk);
        gnt_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("req_queue_drained", exp_req_q.size(), 32'd0);
        chk("instr_queue_drained", exp_ins_q.size(), 32'd0);

        // Wrapping PC and asynchronous reset in WAIT on the second instance.
        @(negedge clk);
        rst2_n = 1'b1;
        bus2.imem_gnt = 1'b1;
        #3;
        chk("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_req0", {31'b0, bus2.imem_req}, 32'd1);
        @(negedge clk);
        bus2.imem_gnt    = 1'b0;
        bus2.imem_rvalid = 1'b1;
        bus2.imem_rdata  = 32'h00A0_0093;
        #3;
        chk("wrap_wait_req", {31'b0, bus2.imem_req}, 32'd0);
        @(negedge clk);
        bus2.imem_rvalid = 1'b0;
        bus2.instr_ready = 1'b1;
        #3;
        chk("wrap_valid", {31'b0, bus2.instr_valid}, 32'd1);
        chk("wrap_instr_pc", bus2.instr_pc, 32'hFFFF_FFFC);
        chk("wrap_opcode", {25'b0, bus2.opcode}, {25'b0, OP_IMM});
        @(negedge clk);
        bus2.imem_gnt = 1'b1;
        #3;
        chk("wrap_addr1", bus2.imem_addr, 32'h0);
        chk("wrap_req1", {31'b0, bus2.imem_req}, 32'd1);
        @(negedge clk);
        bus2.imem_gnt = 1'b0;
        #3;
        chk("wait2_req", {31'b0, bus2.imem_req}, 32'd0);
        rst2_n = 1'b0;
        #1;
        chk("async_valid", {31'b0, bus2.instr_valid}, 32'd0);
        chk("async_req", {31'b0, bus2.imem_req}, 32'd1);
        chk("async_addr", bus2.imem_addr, 32'hFFFF_FFFC);
        chk("async_instr", bus2.instr, 32'h0000_0013);
        chk("async_instr_pc", bus2.instr_pc, 32'h0);
        @(negedge clk);
        rst2_n = 1'b1;
        bus2.imem_rvalid = 1'b1;
        bus2.imem_rdata  = 32'h0000_A183;
        @(negedge clk);
        bus2.imem_rvalid = 1'b0;
        #3;
        chk("late_rsp_req", {31'b0, bus2.imem_req}, 32'd1);
        chk("late_rsp_valid", {31'b0, bus2.instr_valid}, 32'd0);
        chk("late_rsp_instr", bus2.instr, 32'h0000_0013);
        chk("late_rsp_addr", bus2.imem_addr, 32'hFFFF_FFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit: the producer side of the opcode interface consumed by the main decode controller.
- Holds the PC and issues single-outstanding requests to instruction memory.
- Captures the returned word into an instruction register and presents it, with its PC and `opcode` field, over a valid/ready handshake.
- Accepts PC redirects from branch resolution and discards any in-flight stale fetch.

Parameters:
- XLEN, 32, datapath/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- NOP_INSTR, 32'h0000_0013, instruction register reset value (addi x0,x0,0)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch address, word aligned
- imem_gnt  in  1  memory accepts request this cycle (imem_req && imem_gnt = request taken)
- imem_rvalid  in  1  read data valid; arrives ≥1 cycle after grant
- imem_rdata  in  32  fetched instruction word
- redirect_valid  in  1  load new PC (taken branch/jump)
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored
- instr_valid  out  1  instr/instr_pc/opcode valid
- instr_ready  in  1  consumer accepts instruction
- instr  out  32  instruction register
- instr_pc  out  XLEN  PC of instr
- opcode  out  7  instr[6:0], combinational from instr register

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low on `reset_n`.
- Reset values:
  - state=FETCH, pc=RESET_PC, drop=0
  - instr=NOP_INSTR, instr_pc=0, instr_valid=0
  - imem_req is asserted from the first cycle after reset release.
- Registered state: pc, drop flag, instr, instr_pc, FSM state.
- Output decode: imem_req=(state==FETCH); imem_addr={pc[XLEN-1:2],2'b00}; instr_valid=(state==HOLD).
- FETCH:
  - Hold imem_req=1 until imem_gnt.
  - gnt && !redirect -> WAIT.
  - redirect && !gnt -> pc<=redirect_pc, stay FETCH.
  - redirect && gnt -> pc<=redirect_pc, drop<=1, -> WAIT.
- WAIT:
  - imem_req=0.
  - redirect without rvalid -> pc<=redirect_pc, drop<=1.
  - rvalid with (drop || redirect): discard data, drop<=0, pc<=redirect ? redirect_pc : pc, -> FETCH.
  - rvalid clean: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, -> HOLD.
- HOLD:
  - instr_valid=1; instr/instr_pc stable until the handshake.
  - ready && !redirect -> FETCH.
  - redirect (with or without ready) -> pc<=redirect_pc, -> FETCH; instr_valid drops next cycle.
  - If ready was also high, the handshake still counts as a transfer.
- pc+4 arithmetic: modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- Throughput: one outstanding request. Best case one instruction per 3 cycles (FETCH, WAIT, HOLD) with single-cycle memory.
- rvalid outside WAIT: ignored; the memory protocol guarantees it does not happen.
- Reset asserted mid-fetch: all state returns to reset values immediately. A response arriving after release, while in FETCH, is ignored.
- instr latency: visible the cycle after a clean rvalid.

Decomposition:
- Shared package (riscv_pkg), holding:
  - XLEN
  - NOP_INSTR
  - opcode constants: OP_BRANCH 7'b1100011, OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_IMM 7'b0010011, OP_REG 7'b0110011
  - fetch FSM state encoding (FETCH=2'd0, WAIT=2'd1, HOLD=2'd2)
- These opcode constants are shared with the decode controller.
- No sub-module; the PC register and the FSM live in one module.

Test Plan:
- Reset release, memory grants immediately, rvalid +1 cycle with 32'h00A00093, instr_ready=1 → imem_addr 0, 4, 8 on successive FETCH states; instr=32'h00A00093, opcode=7'b0010011, instr_pc=0; instr_valid pulses once per 3 cycles.
- Back-pressure: instr_ready=0 for 5 cycles in HOLD → instr_valid stays 1, instr/instr_pc stable, imem_req=0; ready=1 → next request at addr 8.
- Redirect in WAIT to 32'h0000_0103 → response discarded (instr_valid stays 0); next imem_addr=32'h0000_0100; its data is presented with instr_pc=32'h100.
- Redirect coincident with gnt in FETCH (target 0x40) → the granted response is dropped; the next request is 0x40.
- Redirect coincident with instr_ready in HOLD (target 0x80) → transfer completes; next imem_addr=0x80; no duplicate instr_valid.
- RESET_PC=32'hFFFF_FFFC → first fetch 0xFFFF_FFFC, second fetch 0x0; reset_n asserted in WAIT → outputs return to reset values asynchronously.
